// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - single-port pixel/data RAM arbiter with raster-order pixel prefetch FIFO
module vram_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 8,
    parameter int FIFO_DEPTH   = 8,
    parameter int LOW_WM       = 2,
    parameter int FRAME_PIXELS = 65536
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              vga_enable,
    input  logic              pix_pop,
    output logic              pix_valid,
    output logic [DATA_W-1:0] pix_data,
    output logic              pix_underrun,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [1:0] ST_DISABLED = 2'd0;
    localparam logic [1:0] ST_FILL     = 2'd1;
    localparam logic [1:0] ST_RUN      = 2'd2;

    localparam logic [ADDR_W-1:0] SCAN_LAST = ADDR_W'(FRAME_PIXELS - 1);
    localparam logic [CW-1:0]     DEPTH_C   = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0]     LOW_WM_C  = CW'(LOW_WM);

    logic [1:0]        state;
    logic [CW-1:0]     count;
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
    logic              inflight;
    logic              load_pend;
    logic [ADDR_W-1:0] scan_addr;
    logic [ADDR_W-1:0] last_addr;

    logic              scan_on;
    logic [CW-1:0]     level;
    logic              vga_elig;
    logic              urgent;
    logic              vga_fetch;
    logic              push;
    logic              pop;
    logic              pop_empty;

    // Scanning stops in the very cycle vga_enable drops, so a returning pixel is discarded.
    assign scan_on   = vga_enable && (state != ST_DISABLED);
    assign level     = count + CW'(inflight);
    assign vga_elig  = scan_on && (level < DEPTH_C);
    assign urgent    = (level <= LOW_WM_C);
    assign push      = inflight && scan_on;
    assign pop       = pix_pop && scan_on && (count != '0);
    assign pop_empty = pix_pop && scan_on && (count == '0);

    always_comb begin
        vga_fetch = 1'b0;
        cpu_gnt   = 1'b0;
        if (vga_elig && ((state == ST_FILL) || urgent)) begin
            vga_fetch = 1'b1;
        end else if (cpu_req) begin
            cpu_gnt = 1'b1;
        end else if (vga_elig) begin
            vga_fetch = 1'b1;
        end
    end

    assign mem_addr  = vga_fetch ? scan_addr : (cpu_gnt ? cpu_addr : last_addr);
    assign mem_we    = cpu_gnt && cpu_we;
    assign mem_wdata = mem_we ? cpu_wdata : '0;
    assign pix_valid = (count != '0);
    assign pix_data  = pix_valid ? fifo_mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= mem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= ST_DISABLED;
            count        <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            inflight     <= 1'b0;
            load_pend    <= 1'b0;
            scan_addr    <= '0;
            last_addr    <= '0;
            cpu_rvalid   <= 1'b0;
            cpu_rdata    <= '0;
            pix_underrun <= 1'b0;
        end else begin
            last_addr  <= mem_addr;
            load_pend  <= cpu_gnt && !cpu_we;
            cpu_rvalid <= load_pend;
            if (load_pend) begin
                cpu_rdata <= mem_rdata;
            end

            if (!vga_enable) begin
                state        <= ST_DISABLED;
                count        <= '0;
                wr_ptr       <= '0;
                rd_ptr       <= '0;
                inflight     <= 1'b0;
                scan_addr    <= '0;
                pix_underrun <= 1'b0;
            end else begin
                case (state)
                    ST_DISABLED: state <= ST_FILL;
                    ST_FILL:     if (count == DEPTH_C) state <= ST_RUN;
                    default:     state <= state;
                endcase
                inflight <= vga_fetch;
                if (vga_fetch) begin
                    scan_addr <= (scan_addr == SCAN_LAST) ? '0 : scan_addr + 1'b1;
                end
                if (push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                count <= count + CW'(push) - CW'(pop);
                if (pop_empty) begin
                    pix_underrun <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// tb/tb_vram_arbiter.sv - directed self-checking bench for vram_arbiter
module tb_vram_arbiter;

    logic        clk;
    logic        reset;
    logic        cpu_req;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_gnt;
    logic        cpu_rvalid;
    logic [7:0]  cpu_rdata;
    logic        vga_enable;
    logic        pix_pop;
    logic        pix_valid;
    logic [7:0]  pix_data;
    logic        pix_underrun;
    logic [15:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    int n_cmp;
    int n_err;

    logic [7:0] ram [0:65535];

    vram_arbiter dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .vga_enable(vga_enable), .pix_pop(pix_pop), .pix_valid(pix_valid),
        .pix_data(pix_data), .pix_underrun(pix_underrun),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: one-cycle read latency, preloaded with data = addr[7:0]
    initial begin
        for (int a = 0; a < 65536; a++) ram[a] = a[7:0];
    end
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0; cpu_wdata = 8'h0;
        vga_enable = 1'b0; pix_pop = 1'b0;
        repeat (3) cyc();
        #1;
        n_cmp++; if ({cpu_gnt, cpu_rvalid, cpu_rdata, pix_valid, pix_data, pix_underrun, mem_we, mem_addr, mem_wdata} !== 45'h0) begin
            n_err++; $display("FAIL reset_outputs: got gnt=%b rv=%b rd=%h pv=%b pd=%h ur=%b we=%b a=%h wd=%h want all 0",
                cpu_gnt, cpu_rvalid, cpu_rdata, pix_valid, pix_data, pix_underrun, mem_we, mem_addr, mem_wdata);
        end
        cyc(); reset = 1'b1;
    endtask

    task automatic cpu_store_load(input logic [15:0] a, input logic [7:0] d, input string tag);
        cyc(); cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_wdata = d; #1;
        n_cmp++; if ({cpu_gnt, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, a, d}) begin
            n_err++; $display("FAIL %s_store: got gnt=%b we=%b a=%h wd=%h want 1 1 %h %h", tag, cpu_gnt, mem_we, mem_addr, mem_wdata, a, d);
        end
        cyc(); cpu_we = 1'b0; #1;
        n_cmp++; if ({cpu_gnt, mem_we, mem_addr} !== {1'b1, 1'b0, a}) begin
            n_err++; $display("FAIL %s_load_gnt: got gnt=%b we=%b a=%h want 1 0 %h", tag, cpu_gnt, mem_we, mem_addr, a);
        end
        cyc(); cpu_req = 1'b0; #1;
        n_cmp++; if (cpu_rvalid !== 1'b0) begin
            n_err++; $display("FAIL %s_rvalid_t1: got %b want 0", tag, cpu_rvalid);
        end
        cyc(); #1;
        n_cmp++; if ({cpu_rvalid, cpu_rdata} !== {1'b1, d}) begin
            n_err++; $display("FAIL %s_rvalid_t2: got rv=%b rd=%h want 1 %h", tag, cpu_rvalid, cpu_rdata, d);
        end
        cyc(); #1;
        n_cmp++; if ({cpu_rvalid, cpu_rdata} !== {1'b0, d}) begin
            n_err++; $display("FAIL %s_rvalid_pulse: got rv=%b rd=%h want 0 %h", tag, cpu_rvalid, cpu_rdata, d);
        end
    endtask

    task automatic test_cpu_disabled();
        cpu_store_load(16'h0010, 8'hA5, "cpu_a5");
        cpu_store_load(16'h0010, 8'h10, "cpu_restore");
    endtask

    task automatic test_fill();
        cyc(); vga_enable = 1'b1;
        for (int k = 0; k < 8; k++) begin
            cyc(); #1;
            n_cmp++; if ({mem_addr, mem_we} !== {16'(k), 1'b0}) begin
                n_err++; $display("FAIL fill_fetch%0d: got a=%h we=%b want %h 0", k, mem_addr, mem_we, k);
            end
        end
        for (int k = 0; k < 6; k++) begin
            cyc(); #1;
            n_cmp++; if (mem_addr !== 16'h0007) begin
                n_err++; $display("FAIL fill_nofetch%0d: got a=%h want 0007", k, mem_addr);
            end
        end
        n_cmp++; if ({pix_valid, pix_data} !== {1'b1, 8'h00}) begin
            n_err++; $display("FAIL fill_head: got v=%b d=%h want 1 00", pix_valid, pix_data);
        end
    endtask

    task automatic test_run_watermark();
        int gnts;
        int invalid;
        logic [7:0] exp_pix;
        gnts = 0; invalid = 0; exp_pix = 8'h00;
        for (int k = 0; k < 20; k++) begin
            cyc(); cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0100; pix_pop = pix_valid; #1;
            if (cpu_gnt) gnts++;
            if (!pix_pop) invalid++;
            n_cmp++; if (pix_data !== exp_pix) begin
                n_err++; $display("FAIL run_pixel%0d: got %h want %h", k, pix_data, exp_pix);
            end
            exp_pix = exp_pix + 8'd1;
        end
        n_cmp++; if (gnts !== 6) begin
            n_err++; $display("FAIL run_cpu_grants: got %0d want 6", gnts);
        end
        n_cmp++; if (invalid !== 0) begin
            n_err++; $display("FAIL run_fifo_empty: got %0d empty cycles want 0", invalid);
        end
        cyc(); cpu_req = 1'b0; pix_pop = 1'b0;
        repeat (4) cyc();
        vga_enable = 1'b0;
        cyc(); #1;
        n_cmp++; if ({pix_valid, pix_data} !== {1'b0, 8'h00}) begin
            n_err++; $display("FAIL disable_flush: got v=%b d=%h want 0 00", pix_valid, pix_data);
        end
        repeat (2) cyc();
    endtask

    task automatic test_underrun();
        cyc(); pix_pop = 1'b1;
        cyc(); pix_pop = 1'b0; #1;
        n_cmp++; if (pix_underrun !== 1'b0) begin
            n_err++; $display("FAIL underrun_disabled: got %b want 0", pix_underrun);
        end
        vga_enable = 1'b1;
        cyc(); pix_pop = 1'b1;
        cyc(); pix_pop = 1'b0; #1;
        n_cmp++; if (pix_underrun !== 1'b1) begin
            n_err++; $display("FAIL underrun_set: got %b want 1", pix_underrun);
        end
        cyc(); #1;
        n_cmp++; if ({pix_valid, pix_data} !== {1'b1, 8'h00}) begin
            n_err++; $display("FAIL underrun_fifo_kept: got v=%b d=%h want 1 00", pix_valid, pix_data);
        end
        repeat (5) cyc();
        #1;
        n_cmp++; if (pix_underrun !== 1'b1) begin
            n_err++; $display("FAIL underrun_sticky: got %b want 1", pix_underrun);
        end
        cyc(); vga_enable = 1'b0;
        cyc(); #1;
        n_cmp++; if (pix_underrun !== 1'b0) begin
            n_err++; $display("FAIL underrun_clear: got %b want 0", pix_underrun);
        end
    endtask

    task automatic test_reset_inflight();
        cyc(); vga_enable = 1'b1;
        repeat (14) cyc();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0003; #1;
        n_cmp++; if (cpu_gnt !== 1'b1) begin
            n_err++; $display("FAIL rst_load_gnt: got %b want 1", cpu_gnt);
        end
        cyc(); cpu_req = 1'b0; reset = 1'b0;
        cyc(); #1;
        n_cmp++; if ({cpu_gnt, cpu_rvalid, cpu_rdata, pix_valid, pix_data, pix_underrun, mem_we, mem_addr, mem_wdata} !== 45'h0) begin
            n_err++; $display("FAIL rst_outputs: got gnt=%b rv=%b rd=%h pv=%b pd=%h ur=%b we=%b a=%h wd=%h want all 0",
                cpu_gnt, cpu_rvalid, cpu_rdata, pix_valid, pix_data, pix_underrun, mem_we, mem_addr, mem_wdata);
        end
        cyc(); reset = 1'b1; cpu_req = 1'b1; cpu_addr = 16'h0005; #1;
        n_cmp++; if ({cpu_gnt, cpu_rvalid} !== 2'b10) begin
            n_err++; $display("FAIL rst_disabled_state: got gnt=%b rv=%b want 1 0", cpu_gnt, cpu_rvalid);
        end
        cyc(); #1;
        n_cmp++; if ({cpu_gnt, mem_addr} !== {1'b0, 16'h0000}) begin
            n_err++; $display("FAIL rst_refill: got gnt=%b a=%h want 0 0000", cpu_gnt, mem_addr);
        end
        cpu_req = 1'b0;
        cyc(); vga_enable = 1'b0;
        repeat (3) cyc();
    endtask

    task automatic test_scan_wrap();
        logic [15:0] seq [3];
        int          got;
        bit          seen;
        bit          have_prev;
        logic [7:0]  prev;
        int          cont_err;
        int          first_pix;
        got = 0; seen = 0; have_prev = 0; prev = 8'h00; cont_err = 0; first_pix = -1;
        cyc(); vga_enable = 1'b1;
        for (int k = 0; k < 70000 && got < 3; k++) begin
            cyc(); pix_pop = pix_valid; #1;
            if (seen) begin
                seq[got] = mem_addr;
                got++;
            end else if (mem_addr == 16'hFFFE) begin
                seen = 1;
            end
            if (pix_pop) begin
                if (first_pix < 0) first_pix = int'(pix_data);
                if (have_prev && pix_data !== prev + 8'd1) cont_err++;
                prev = pix_data; have_prev = 1;
            end
        end
        n_cmp++; if (got !== 3) begin
            n_err++; $display("FAIL wrap_timeout: got %0d samples after FFFE want 3", got);
        end else begin
            n_cmp++; if ({seq[0], seq[1], seq[2]} !== {16'hFFFF, 16'h0000, 16'h0001}) begin
                n_err++; $display("FAIL wrap_order: got %h %h %h want ffff 0000 0001", seq[0], seq[1], seq[2]);
            end
        end
        n_cmp++; if (first_pix !== 0) begin
            n_err++; $display("FAIL wrap_first_pixel: got %0d want 0", first_pix);
        end
        n_cmp++; if (cont_err !== 0) begin
            n_err++; $display("FAIL wrap_continuity: got %0d breaks want 0", cont_err);
        end
        cyc(); pix_pop = 1'b0; vga_enable = 1'b0;
        repeat (2) cyc();
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        test_reset();
        test_cpu_disabled();
        test_fill();
        test_run_watermark();
        test_underrun();
        test_reset_inflight();
        test_scan_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
